mcd_buddy_alloc_responder: RTL and testbench

- Responder end of the memcached allocation stream: accepts 57-bit alloc/free requests from the memcached pipeline and returns 40-bit results.
- Manages a bitmap of NUM_BLOCKS equal-size DRAM blocks using buddy-aligned power-of-two allocation.
- Sits beside the memcached pipeline top in the apclk domain. Its allocated addresses feed the value-store DRAM path.

---
 rtl/mcd_buddy_alloc_responder_if.sv | 28 ++
 rtl/mcd_buddy_alloc_responder.sv | 146 ++++++++++++++
 tb/tb_mcd_buddy_alloc_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcd_buddy_alloc_responder_if.sv
// Request/response stream pair between the memcached pipeline (master) and
// the buddy allocator responder (slave).
interface mcd_buddy_alloc_responder_if;
    logic [56:0] alloc_tdata;
    logic        alloc_tvalid;
    logic        alloc_tready;
    logic [39:0] alloc_ret_tdata;
    logic        alloc_ret_tvalid;
    logic        alloc_ret_tready;

    modport master (
        output alloc_tdata,
        output alloc_tvalid,
        input  alloc_tready,
        input  alloc_ret_tdata,
        input  alloc_ret_tvalid,
        output alloc_ret_tready
    );

    modport slave (
        input  alloc_tdata,
        input  alloc_tvalid,
        output alloc_tready,
        output alloc_ret_tdata,
        output alloc_ret_tvalid,
        input  alloc_ret_tready
    );
endinterface

// File: rtl/mcd_buddy_alloc_responder.sv
// Buddy-aligned power-of-two block allocator over a NUM_BLOCKS bitmap, serving
// one alloc/free request at a time on the memcached allocation stream.
module mcd_buddy_alloc_responder #(
    parameter int unsigned NUM_BLOCKS  = 64,
    parameter int unsigned BLOCK_SHIFT = 20,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_ORDER   = 6
) (
    input  logic                              apclk,
    input  logic                              apresetn,
    mcd_buddy_alloc_responder_if.slave        alloc,
    output logic [$clog2(NUM_BLOCKS+1)-1:0]   free_cnt
);

    localparam int unsigned CW = $clog2(NUM_BLOCKS) + 1;
    localparam int unsigned FW = $clog2(NUM_BLOCKS + 1);
    localparam logic [CW-1:0]         NB       = CW'(NUM_BLOCKS);
    localparam logic [NUM_BLOCKS-1:0] ALL_ONES = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FCHK = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state;
    logic                  op_q;
    logic [7:0]            order_q;
    logic [31:0]           addr_q;
    logic [CW-1:0]         cand;
    logic [NUM_BLOCKS-1:0] bitmap;
    logic [39:0]           ret_data;
    logic                  ret_valid;

    logic                  unused_reserved;
    logic [CW-1:0]         size;
    logic                  order_bad;
    logic [CW-1:0]         region_base;
    logic [NUM_BLOCKS-1:0] mask;
    logic                  region_free;
    logic                  region_busy;
    logic [CW-1:0]         cand_next;
    logic                  scan_last;
    logic [32:0]           diff;
    logic                  below_base;
    logic [31:0]           idx_full;
    logic [31:0]           size32;
    logic                  misaligned;
    logic                  idx_unaligned;
    logic                  out_of_range;
    logic                  free_bad;
    logic [31:0]           alloc_addr;

    assign unused_reserved = ^alloc.alloc_tdata[47:32];

    // Region size is 0 for an illegal order; every use is gated by order_bad.
    assign size      = CW'(1) << order_q;
    assign order_bad = order_q > 8'(MAX_ORDER);

    assign diff       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign below_base = diff[32];
    assign idx_full   = diff[31:0] >> BLOCK_SHIFT;
    assign size32     = 32'(size);

    // One mask generator shared by the alloc scan and the free check.
    assign region_base = (state == FCHK) ? idx_full[CW-1:0] : cand;
    assign mask        = (ALL_ONES >> (NB - size)) << region_base;
    assign region_free = (bitmap & mask) == '0;
    assign region_busy = (bitmap & mask) == mask;

    assign cand_next = cand + size;
    assign scan_last = cand_next >= NB;
    assign alloc_addr = BASE_ADDR + (32'(cand) << BLOCK_SHIFT);

    assign misaligned    = addr_q[BLOCK_SHIFT-1:0] != '0;
    assign idx_unaligned = (idx_full & (size32 - 32'd1)) != '0;
    assign out_of_range  = ({1'b0, idx_full} + {1'b0, size32}) > 33'(NUM_BLOCKS);
    assign free_bad = order_bad || below_base || misaligned || idx_unaligned ||
                      out_of_range || !region_busy;

    assign alloc.alloc_tready     = (state == IDLE);
    assign alloc.alloc_ret_tvalid = ret_valid;
    assign alloc.alloc_ret_tdata  = ret_data;

    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            state     <= IDLE;
            op_q      <= 1'b0;
            order_q   <= '0;
            addr_q    <= '0;
            cand      <= '0;
            bitmap    <= '0;
            free_cnt  <= FW'(NUM_BLOCKS);
            ret_data  <= '0;
            ret_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (alloc.alloc_tvalid) begin
                        op_q    <= alloc.alloc_tdata[56];
                        order_q <= alloc.alloc_tdata[55:48];
                        addr_q  <= alloc.alloc_tdata[31:0];
                        cand    <= '0;
                        state   <= alloc.alloc_tdata[56] ? FCHK : SCAN;
                    end
                end
                SCAN: begin
                    if (order_bad) begin
                        ret_data <= {6'b0, 1'b0, 1'b1, 32'h0};
                        state    <= RESP;
                    end else if (region_free) begin
                        bitmap   <= bitmap | mask;
                        free_cnt <= free_cnt - FW'(size);
                        ret_data <= {6'b0, 1'b0, 1'b0, alloc_addr};
                        state    <= RESP;
                    end else if (scan_last) begin
                        ret_data <= {6'b0, 1'b0, 1'b1, 32'h0};
                        state    <= RESP;
                    end else begin
                        cand <= cand_next;
                    end
                end
                FCHK: begin
                    if (free_bad) begin
                        ret_data <= {6'b0, 1'b1, 1'b1, addr_q};
                    end else begin
                        bitmap   <= bitmap & ~mask;
                        free_cnt <= free_cnt + FW'(size);
                        ret_data <= {6'b0, 1'b1, 1'b0, addr_q};
                    end
                    state <= RESP;
                end
                RESP: begin
                    // Response data settles on entry; valid rises one cycle later.
                    if (!ret_valid) begin
                        ret_valid <= 1'b1;
                    end else if (alloc.alloc_ret_tready) begin
                        ret_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcd_buddy_alloc_responder.sv
// Directed plus randomized check of the buddy allocator against a block-array model.
module tb_mcd_buddy_alloc_responder;

    logic       apclk = 1'b0;
    logic       apresetn = 1'b0;
    logic [6:0] free_cnt;

    always #5 apclk = ~apclk;

    mcd_buddy_alloc_responder_if bus ();

    mcd_buddy_alloc_responder #(
        .NUM_BLOCKS (64),
        .BLOCK_SHIFT(20),
        .BASE_ADDR  (32'h0000_0000),
        .MAX_ORDER  (6)
    ) dut (
        .apclk   (apclk),
        .apresetn(apresetn),
        .alloc   (bus),
        .free_cnt(free_cnt)
    );

    int tests = 0;
    int fails = 0;
    bit busy [64];
    int model_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy[i]) busy[i] = 1'b0;
        model_cnt = 64;
    endtask

    // Reference: first-fit over aligned candidates, plain array bookkeeping.
    task automatic model_op(input bit op, input int order, input logic [31:0] addr,
                            output logic [39:0] exp, output int lat);
        int size;
        int found;
        int idx;
        bit ok;
        bit bad;
        size = 0;
        if (!op) begin
            if (order > 6) begin
                exp = {6'b0, 1'b0, 1'b1, 32'h0};
                lat = 2;
            end else begin
                size  = 1 << order;
                found = -1;
                for (int c = 0; c < 64 && found < 0; c += size) begin
                    ok = 1'b1;
                    for (int j = 0; j < size; j++) if (busy[c+j]) ok = 1'b0;
                    if (ok) found = c;
                end
                if (found >= 0) begin
                    for (int j = 0; j < size; j++) busy[found+j] = 1'b1;
                    model_cnt -= size;
                    exp = {6'b0, 1'b0, 1'b0, 32'(found * (1 << 20))};
                    lat = found / size + 2;
                end else begin
                    exp = {6'b0, 1'b0, 1'b1, 32'h0};
                    lat = 64 / size + 1;
                end
            end
        end else begin
            bad = 1'b0;
            idx = int'(addr / 32'h0010_0000);
            if (order > 6) bad = 1'b1;
            else size = 1 << order;
            if (addr % 32'h0010_0000 != 0) bad = 1'b1;
            if (!bad && ((idx % size) != 0 || idx + size > 64)) bad = 1'b1;
            if (!bad) for (int j = 0; j < size; j++) if (!busy[idx+j]) bad = 1'b1;
            if (!bad) begin
                for (int j = 0; j < size; j++) busy[idx+j] = 1'b0;
                model_cnt += size;
            end
            exp = {6'b0, 1'b1, bad, addr};
            lat = 2;
        end
    endtask

    task automatic do_op(input string tag, input bit op, input int order,
                         input logic [31:0] addr, input int stall, output logic [39:0] got);
        logic [39:0] exp;
        int elat;
        int lat;
        int guard;
        model_op(op, order, addr, exp, elat);
        got = '0;
        @(negedge apclk);
        guard = 0;
        while (!bus.alloc_tready && guard < 50) begin
            @(negedge apclk);
            guard++;
        end
        if (!bus.alloc_tready) begin
            check({tag, " accept timeout"}, 64'd0, 64'd1);
            return;
        end
        bus.alloc_tdata      = {op, 8'(order), 16'($urandom), addr};
        bus.alloc_tvalid     = 1'b1;
        bus.alloc_ret_tready = (stall == 0);
        @(posedge apclk);
        #1;
        bus.alloc_tvalid = 1'b0;
        bus.alloc_tdata  = '0;
        lat = 0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge apclk);
            #1;
            if (bus.alloc_ret_tvalid) lat = n;
        end
        if (lat == 0) begin
            check({tag, " response timeout"}, 64'd0, 64'd1);
            return;
        end
        got = bus.alloc_ret_tdata;
        check({tag, " data"}, 64'(got), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " free_cnt"}, 64'(free_cnt), 64'(model_cnt));
        for (int s = 0; s < stall; s++) begin
            @(posedge apclk);
            #1;
            check({tag, " stall valid"}, 64'(bus.alloc_ret_tvalid), 64'd1);
            check({tag, " stall data"}, 64'(bus.alloc_ret_tdata), 64'(exp));
            check({tag, " stall tready"}, 64'(bus.alloc_tready), 64'd0);
            check({tag, " stall free_cnt"}, 64'(free_cnt), 64'(model_cnt));
        end
        if (stall > 0) begin
            @(negedge apclk);
            bus.alloc_ret_tready = 1'b1;
        end
        @(posedge apclk);
        #1;
        check({tag, " valid drop"}, 64'(bus.alloc_ret_tvalid), 64'd0);
        check({tag, " idle tready"}, 64'(bus.alloc_tready), 64'd1);
    endtask

    initial begin
        logic [39:0] r;
        int          op;
        int          order;
        int          blk;
        logic [31:0] addr;
        bit          seen;

        bus.alloc_tdata      = '0;
        bus.alloc_tvalid     = 1'b0;
        bus.alloc_ret_tready = 1'b1;
        model_reset();
        repeat (3) @(negedge apclk);
        #1;
        check("reset free_cnt", 64'(free_cnt), 64'd64);
        check("reset tready", 64'(bus.alloc_tready), 64'd1);
        check("reset ret_tvalid", 64'(bus.alloc_ret_tvalid), 64'd0);
        check("reset ret_tdata", 64'(bus.alloc_ret_tdata), 64'd0);
        @(negedge apclk);
        apresetn = 1'b1;

        do_op("alloc0 first", 1'b0, 0, 32'h0, 0, r);
        check("alloc0 first addr", 64'(r), 64'(40'h00_0000_0000));
        do_op("alloc0 second", 1'b0, 0, 32'h0, 0, r);
        check("alloc0 second addr", 64'(r), 64'(40'h00_0010_0000));
        check("after two allocs free_cnt", 64'(free_cnt), 64'd62);
        do_op("alloc2", 1'b0, 2, 32'h0, 0, r);
        check("alloc2 addr", 64'(r), 64'(40'h00_0040_0000));
        check("after alloc2 free_cnt", 64'(free_cnt), 64'd58);

        do_op("free blk1", 1'b1, 0, 32'h0010_0000, 0, r);
        check("free blk1 resp", 64'(r), 64'(40'h02_0010_0000));
        check("free blk1 free_cnt", 64'(free_cnt), 64'd59);
        do_op("double free", 1'b1, 0, 32'h0010_0000, 0, r);
        check("double free resp", 64'(r), 64'(40'h03_0010_0000));
        check("double free free_cnt", 64'(free_cnt), 64'd59);
        do_op("misaligned free", 1'b1, 0, 32'h0010_0004, 0, r);
        check("misaligned free fail", 64'(r[32]), 64'd1);

        do_op("alloc6 busy stall", 1'b0, 6, 32'h0, 5, r);
        check("alloc6 resp", 64'(r), 64'(40'h01_0000_0000));
        do_op("alloc7", 1'b0, 7, 32'h0, 0, r);
        check("alloc7 resp", 64'(r), 64'(40'h01_0000_0000));

        for (int it = 0; it < 120; it++) begin
            op = int'($urandom_range(0, 1));
            if (op == 0) begin
                order = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 12))
                                                    : int'($urandom_range(0, 3));
                do_op("rand alloc", 1'b0, order, 32'($urandom), int'($urandom_range(0, 2)), r);
            end else begin
                order = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 3));
                blk   = int'($urandom_range(0, 63));
                if (order <= 6) blk = blk & ~((1 << order) - 1);
                addr = 32'(blk) << 20;
                if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 255));
                do_op("rand free", 1'b1, order, addr, int'($urandom_range(0, 2)), r);
            end
        end

        // Clean state, occupy blocks 0..2, then reset while cand 3 is pending.
        @(negedge apclk);
        apresetn = 1'b0;
        model_reset();
        repeat (2) @(negedge apclk);
        apresetn = 1'b1;
        for (int i = 0; i < 3; i++) do_op("prefill", 1'b0, 0, 32'h0, 0, r);
        check("prefill free_cnt", 64'(free_cnt), 64'd61);
        @(negedge apclk);
        bus.alloc_tdata  = {1'b0, 8'd0, 16'h0, 32'h0};
        bus.alloc_tvalid = 1'b1;
        @(posedge apclk);
        #1;
        bus.alloc_tvalid = 1'b0;
        repeat (3) @(posedge apclk);
        #1;
        apresetn = 1'b0;
        #1;
        model_reset();
        check("midscan reset tvalid", 64'(bus.alloc_ret_tvalid), 64'd0);
        check("midscan reset free_cnt", 64'(free_cnt), 64'd64);
        check("midscan reset tready", 64'(bus.alloc_tready), 64'd1);
        check("midscan reset tdata", 64'(bus.alloc_ret_tdata), 64'd0);
        repeat (2) @(negedge apclk);
        apresetn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge apclk);
            #1;
            if (bus.alloc_ret_tvalid) seen = 1'b1;
        end
        check("no response after reset", 64'(seen), 64'd0);
        do_op("post reset alloc0", 1'b0, 0, 32'h0, 0, r);
        check("post reset addr", 64'(r), 64'(40'h00_0000_0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
